seg_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for a bank of common-anode seven-segment digits sharing one segment bus.
- Holds a 32-bit hex display value written by the CPU-side bus, selects one digit per scan slot, and feeds its nibble through a `seven_segment_encoder` instance.
- Adds anti-ghosting guard time, leading-zero suppression, blink and tear-free frame-boundary updates.
- Sits between the memory-mapped display register and the board's digit/segment pins.

---
 rtl/seg_pkg.sv | 33 +++
 rtl/seven_segment_encoder.sv | 37 +++
 rtl/seg_scan_ctrl.sv | 173 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants, slot-phase type and leading-zero helper for the
// seven-segment scan controller.
package seg_pkg;

  localparam logic [6:0] SEG_ALL_OFF = 7'h7f;
  localparam logic [7:0] DIG_ALL_OFF = 8'hff;
  localparam int unsigned MAX_DIGITS = 8;

  typedef enum logic {
    PH_GUARD,
    PH_ACTIVE
  } slot_phase_e;

  // Bit i set when digit i is a leading zero: i > 0 and nibbles
  // i..num_digits-1 of value are all zero. Digit 0 is never flagged.
  function automatic logic [7:0] lz_mask(input logic [31:0] value,
                                         input int unsigned num_digits);
    logic [7:0]  mask;
    logic        zero_above;
    int unsigned i;
    mask       = '0;
    zero_above = 1'b1;
    for (int unsigned k = 0; k < MAX_DIGITS; k++) begin
      i = MAX_DIGITS - 1 - k;
      if (i < num_digits) begin
        zero_above = zero_above & (value[4*i +: 4] == 4'h0);
        mask[i]    = zero_above & (i != 0);
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/seven_segment_encoder.sv
// Hex nibble to common-anode segment pattern {dp, g..a}, all active-low.
// Holding rst_n low blanks every segment including the decimal point.
module seven_segment_encoder
  import seg_pkg::*;
(
  input  logic       rst_n,
  input  logic [3:0] data,
  input  logic       dp,
  output logic [7:0] seg_n
);

  always_comb begin
    seg_n = {1'b1, SEG_ALL_OFF};
    if (rst_n) begin
      seg_n[7] = ~dp;
      unique case (data)
        4'h0: seg_n[6:0] = 7'h40;
        4'h1: seg_n[6:0] = 7'h79;
        4'h2: seg_n[6:0] = 7'h24;
        4'h3: seg_n[6:0] = 7'h30;
        4'h4: seg_n[6:0] = 7'h19;
        4'h5: seg_n[6:0] = 7'h12;
        4'h6: seg_n[6:0] = 7'h02;
        4'h7: seg_n[6:0] = 7'h78;
        4'h8: seg_n[6:0] = 7'h00;
        4'h9: seg_n[6:0] = 7'h10;
        4'ha: seg_n[6:0] = 7'h08;
        4'hb: seg_n[6:0] = 7'h03;
        4'hc: seg_n[6:0] = 7'h46;
        4'hd: seg_n[6:0] = 7'h21;
        4'he: seg_n[6:0] = 7'h06;
        4'hf: seg_n[6:0] = 7'h0e;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode seven-segment digits:
// guard time, leading-zero suppression, blink and frame-boundary commit.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned GUARD        = 16,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  wr_en,
  input  logic [31:0]           wr_data,
  input  logic [3:0]            wr_be,
  input  logic                  lz_suppress,
  input  logic                  blink_en,
  input  logic [7:0]            dp_mask,
  output logic [NUM_DIGITS-1:0] digit_sel_n,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic                  frame_pulse
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] GUARD_END  = PW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = DIG_ALL_OFF[NUM_DIGITS-1:0];

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [31:0]           pending_q, pending_d;
  logic [31:0]           display_q, display_d;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  blink_ph_q, blink_ph_d;
  logic [NUM_DIGITS-1:0] digit_sel_n_q, digit_sel_n_d;
  logic [6:0]            seg_n_q, seg_n_d;
  logic                  dp_n_q, dp_n_d;
  logic                  frame_pulse_q, frame_pulse_d;

  logic                  slot_end;
  logic                  frame_wrap;
  slot_phase_e           phase;
  logic [7:0]            lz_bits;
  logic [3:0]            nibble;
  logic [NUM_DIGITS-1:0] sel_n;
  logic                  dp_sel;
  logic                  lz_sel;
  logic                  blank;
  logic                  enc_rst_n;
  logic [7:0]            enc_seg;

  always_comb begin
    pending_d = pending_q;
    if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          pending_d[8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
  end

  // The commit takes pending_d so a write landing on the wrap cycle is shown.
  always_comb begin
    slot_end    = en && (presc_q == PRESC_LAST);
    frame_wrap  = slot_end && (idx_q == IDX_LAST);
    presc_d     = presc_q;
    idx_d       = idx_q;
    display_d   = display_q;
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (!en) begin
      presc_d = '0;
      idx_d   = '0;
    end else if (slot_end) begin
      presc_d = '0;
      idx_d   = frame_wrap ? '0 : idx_q + 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
    if (frame_wrap) begin
      display_d = pending_d;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  assign lz_bits = lz_mask(display_q, NUM_DIGITS);

  always_comb begin
    nibble = '0;
    sel_n  = SEL_OFF;
    dp_sel = 1'b0;
    lz_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nibble   = display_q[4*i +: 4];
        sel_n[i] = 1'b0;
        dp_sel   = dp_mask[i];
        lz_sel   = lz_bits[i];
      end
    end
  end

  assign blank     = (lz_suppress & lz_sel) | (blink_en & blink_ph_q);
  assign enc_rst_n = ~blank;
  assign phase     = (presc_q < GUARD_END) ? PH_GUARD : PH_ACTIVE;

  seven_segment_encoder u_enc (
    .rst_n (enc_rst_n),
    .data  (nibble),
    .dp    (dp_sel),
    .seg_n (enc_seg)
  );

  always_comb begin
    digit_sel_n_d = SEL_OFF;
    seg_n_d       = SEG_ALL_OFF;
    dp_n_d        = 1'b1;
    frame_pulse_d = 1'b0;
    if (en) begin
      frame_pulse_d = frame_wrap;
      if (phase == PH_ACTIVE) begin
        digit_sel_n_d = sel_n;
        seg_n_d       = enc_seg[6:0];
        dp_n_d        = enc_seg[7];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q       <= '0;
      idx_q         <= '0;
      pending_q     <= '0;
      display_q     <= '0;
      blink_cnt_q   <= '0;
      blink_ph_q    <= 1'b0;
      digit_sel_n_q <= SEL_OFF;
      seg_n_q       <= SEG_ALL_OFF;
      dp_n_q        <= 1'b1;
      frame_pulse_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      display_q     <= display_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_ph_q    <= blink_ph_d;
      digit_sel_n_q <= digit_sel_n_d;
      seg_n_q       <= seg_n_d;
      dp_n_q        <= dp_n_d;
      frame_pulse_q <= frame_pulse_d;
    end
  end

  assign digit_sel_n = digit_sel_n_q;
  assign seg_n       = seg_n_q;
  assign dp_n        = dp_n_q;
  assign frame_pulse = frame_pulse_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: vector table, corner sequences and a per-cycle
// comparison against a time-based reference model under random stimulus.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int GD = 2;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst, en, wr_en, lz_suppress, blink_en;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [7:0]  dp_mask;
  logic [3:0]  digit_sel_n;
  logic [6:0]  seg_n;
  logic        dp_n, frame_pulse;

  int total = 0;
  int bad   = 0;
  logic chk_on = 1'b0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .GUARD        (GD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_be       (wr_be),
    .lz_suppress (lz_suppress),
    .blink_en    (blink_en),
    .dp_mask     (dp_mask),
    .digit_sel_n (digit_sel_n),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .frame_pulse (frame_pulse)
  );

  function automatic void check(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endfunction

  function automatic logic [6:0] font(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'ha: return 7'h08;  4'hb: return 7'h03;
      4'hc: return 7'h46;  4'hd: return 7'h21;  4'he: return 7'h06;  default: return 7'h0e;
    endcase
  endfunction

  // Reference model: time since scan start gives slot/offset; frames since
  // reset give the blink phase; expected outputs appear one edge later.
  int          m_t, m_frames, m_off, m_slot, m_msd;
  logic [31:0] m_pend, m_disp;
  logic        m_blank;
  logic [3:0]  e_sel;
  logic [6:0]  e_seg;
  logic        e_dp, e_fp;

  always @(posedge clk) begin
    if (rst) begin
      m_t = 0; m_frames = 0; m_pend = '0; m_disp = '0;
      e_sel = 4'hf; e_seg = 7'h7f; e_dp = 1'b1; e_fp = 1'b0;
    end else begin
      e_sel = 4'hf; e_seg = 7'h7f; e_dp = 1'b1; e_fp = 1'b0;
      if (en) begin
        m_off  = m_t % SD;
        m_slot = (m_t / SD) % ND;
        m_msd  = 0;
        for (int i = 0; i < ND; i++) if (m_disp[4*i +: 4] != 4'h0) m_msd = i;
        m_blank = (lz_suppress && m_slot > m_msd) || (blink_en && ((m_frames / BF) % 2 == 1));
        if (m_off >= GD) begin
          e_sel = 4'hf & ~(4'b0001 << m_slot);
          e_seg = m_blank ? 7'h7f : font(m_disp[4*m_slot +: 4]);
          e_dp  = m_blank | ~dp_mask[m_slot];
        end
        e_fp = (m_off == SD - 1) && (m_slot == ND - 1);
      end
      if (wr_en)
        for (int b = 0; b < 4; b++) if (wr_be[b]) m_pend[8*b +: 8] = wr_data[8*b +: 8];
      if (en) begin
        if (e_fp) begin
          m_disp = m_pend;
          m_frames++;
        end
        m_t++;
      end else begin
        m_t = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_sel", digit_sel_n, e_sel);
      check("cyc_seg", seg_n, e_seg);
      check("cyc_dp", dp_n, e_dp);
      check("cyc_fp", frame_pulse, e_fp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (frame_pulse !== 1'b1 && n < 200);
    if (frame_pulse !== 1'b1) check("frame_timeout", frame_pulse, 1);
  endtask

  task automatic wait_sel(input logic [3:0] s);
    int n;
    n = 0;
    while (digit_sel_n !== s && n < 200) begin
      tick();
      n++;
    end
    if (digit_sel_n !== s) check("sel_timeout", digit_sel_n, s);
  endtask

  typedef struct {
    logic [31:0] val;
    logic        lz;
    logic [7:0]  dpm;
    int          digit;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  task automatic apply_vec(input vec_t v);
    logic [3:0] s;
    lz_suppress = v.lz;
    dp_mask     = v.dpm;
    wr_en = 1'b1; wr_data = v.val; wr_be = 4'hf;
    tick();
    wr_en = 1'b0;
    wait_frame();
    tick();
    s = 4'hf & ~(4'b0001 << v.digit);
    wait_sel(s);
    check("vec_seg", seg_n, v.seg);
    check("vec_dp", dp_n, v.dp);
  endtask

  vec_t       vecs[16];
  logic [3:0] first_sel[8];
  logic [6:0] blink_exp[6];

  initial begin
    vecs[0]  = '{32'h0000_1234, 1'b0, 8'h00, 0, 7'h19, 1'b1};
    vecs[1]  = '{32'h0000_1234, 1'b0, 8'h00, 3, 7'h79, 1'b1};
    vecs[2]  = '{32'h0000_1234, 1'b0, 8'h00, 1, 7'h30, 1'b1};
    vecs[3]  = '{32'h0000_1234, 1'b0, 8'h04, 2, 7'h24, 1'b0};
    vecs[4]  = '{32'h0000_1234, 1'b0, 8'h04, 1, 7'h30, 1'b1};
    vecs[5]  = '{32'h0000_0050, 1'b1, 8'h00, 3, 7'h7f, 1'b1};
    vecs[6]  = '{32'h0000_0050, 1'b1, 8'h00, 2, 7'h7f, 1'b1};
    vecs[7]  = '{32'h0000_0050, 1'b1, 8'h00, 1, 7'h12, 1'b1};
    vecs[8]  = '{32'h0000_0050, 1'b1, 8'h00, 0, 7'h40, 1'b1};
    vecs[9]  = '{32'h0000_0000, 1'b1, 8'h00, 0, 7'h40, 1'b1};
    vecs[10] = '{32'h0000_0000, 1'b1, 8'h00, 1, 7'h7f, 1'b1};
    vecs[11] = '{32'h0000_0000, 1'b0, 8'h00, 3, 7'h40, 1'b1};
    vecs[12] = '{32'h0000_00a0, 1'b0, 8'h04, 2, 7'h40, 1'b0};
    vecs[13] = '{32'h0000_00a0, 1'b1, 8'h04, 2, 7'h7f, 1'b1};
    vecs[14] = '{32'habcd_ef00, 1'b0, 8'h00, 3, 7'h06, 1'b1};
    vecs[15] = '{32'h0000_00b8, 1'b1, 8'h00, 0, 7'h00, 1'b1};
    first_sel = '{4'hf, 4'hf, 4'he, 4'he, 4'he, 4'he, 4'he, 4'he};
    blink_exp = '{7'h40, 7'h40, 7'h7f, 7'h7f, 7'h40, 7'h40};

    rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_data = '0; wr_be = '0;
    lz_suppress = 1'b0; blink_en = 1'b0; dp_mask = '0;
    tick();
    tick();
    chk_on = 1'b1;
    check("rst_sel", digit_sel_n, 4'hf);
    check("rst_seg", seg_n, 7'h7f);
    check("rst_dp", dp_n, 1'b1);
    check("rst_fp", frame_pulse, 1'b0);

    // First frame: guard then active, commit deferred to the frame boundary.
    rst = 1'b0; en = 1'b1; wr_en = 1'b1; wr_data = 32'h0000_1234; wr_be = 4'hf;
    for (int i = 0; i < 8; i++) begin
      tick();
      wr_en = 1'b0;
      check("first_slot_sel", digit_sel_n, first_sel[i]);
      if (i == 2) check("frame1_digit0", seg_n, 7'h40);
    end
    wait_frame();
    tick();
    wait_sel(4'he);
    check("frame2_digit0", seg_n, 7'h19);
    wait_sel(4'h7);
    check("frame2_digit3", seg_n, 7'h79);

    for (int i = 0; i < 16; i++) apply_vec(vecs[i]);

    // Byte-enable write landing on the wrap cycle.
    lz_suppress = 1'b0; dp_mask = '0;
    wr_en = 1'b1; wr_data = 32'h1111_1111; wr_be = 4'hf;
    tick();
    wr_en = 1'b0;
    wait_frame();
    repeat (31) tick();
    wr_en = 1'b1; wr_data = 32'habcd_ef00; wr_be = 4'b0010;
    tick();
    wr_en = 1'b0;
    check("merge_fp_hi", frame_pulse, 1'b1);
    tick();
    check("merge_fp_lo", frame_pulse, 1'b0);
    wait_sel(4'hb);
    check("merge_digit2", seg_n, 7'h0e);
    wait_sel(4'h7);
    check("merge_digit3", seg_n, 7'h06);

    // Blink from a fresh reset.
    blink_en = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int f = 0; f < 6; f++) begin
      if (f > 0) begin
        wait_frame();
        tick();
      end
      wait_sel(4'he);
      check("blink_frame", seg_n, blink_exp[f]);
    end
    wait_frame();
    tick();
    wait_sel(4'hd);
    check("blink_blank6", seg_n, 7'h7f);
    blink_en = 1'b0;
    tick();
    check("blink_relight", seg_n, 7'h40);

    // Reset during digit 2 drops both display and pending.
    wr_en = 1'b1; wr_data = 32'h0000_9999; wr_be = 4'hf;
    tick();
    wr_en = 1'b0;
    wait_frame();
    tick();
    wait_sel(4'hb);
    check("pre_rst_digit2", seg_n, 7'h10);
    wr_en = 1'b1; wr_data = 32'h0000_5555;
    tick();
    wr_en = 1'b0; rst = 1'b1;
    tick();
    check("midrst_sel", digit_sel_n, 4'hf);
    check("midrst_seg", seg_n, 7'h7f);
    check("midrst_dp", dp_n, 1'b1);
    check("midrst_fp", frame_pulse, 1'b0);
    rst = 1'b0;
    tick();
    check("restart_g0", digit_sel_n, 4'hf);
    tick();
    check("restart_g1", digit_sel_n, 4'hf);
    tick();
    check("restart_d0", digit_sel_n, 4'he);
    check("restart_seg", seg_n, 7'h40);
    wait_frame();
    tick();
    wait_sel(4'he);
    check("pending_dropped", seg_n, 7'h40);

    // Enable dropped for five cycles mid-slot.
    wait_sel(4'hd);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("en_off_sel", digit_sel_n, 4'hf);
      check("en_off_seg", seg_n, 7'h7f);
    end
    en = 1'b1;
    tick();
    check("en_on_g0", digit_sel_n, 4'hf);
    tick();
    check("en_on_g1", digit_sel_n, 4'hf);
    tick();
    check("en_on_d0", digit_sel_n, 4'he);

    // Random traffic, checked every cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 399) == 0);
      if (en) en = ($urandom_range(0, 149) != 0);
      else    en = ($urandom_range(0, 7) == 0);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_data = $urandom >> (4 * $urandom_range(0, 7));
      wr_be   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) lz_suppress = ~lz_suppress;
      if ($urandom_range(0, 99) == 0) blink_en = ~blink_en;
      if ($urandom_range(0, 29) == 0) dp_mask = 8'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
